// File: rtl/vscale_imem_fifo_responder.sv
// Instruction-memory responder for a vscale core: a host loads instruction words into a FIFO
// through a valid/ready handshake, and the core fetches them in order over an AHB-Lite (HASTI)
// slave port. Reads stall while the FIFO is empty; writes get a two-cycle ERROR response.
// Optional feature: define IMEM_FIFO_ADDR_CHECK_EN to check every fetch against an expected,
// sequentially advancing address, which starts at START_ADDR.
module vscale_imem_fifo_responder #(
    parameter int unsigned DEPTH      = 8,
    parameter logic [31:0] START_ADDR = 32'h200
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              haddr,
    input  logic                     hwrite,
    input  logic [2:0]               hsize,
    input  logic [2:0]               hburst,
    input  logic                     hmastlock,
    input  logic [3:0]               hprot,
    input  logic [1:0]               htrans,
    input  logic [31:0]              hwdata,
    output logic [31:0]              hrdata,
    output logic                     hready,
    output logic                     hresp,
    input  logic                     push_valid,
    input  logic [31:0]              push_data,
    output logic                     push_ready,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DepthC = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StRd, StErr1, StErr2} state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [CW-1:0]   count_q;
    logic [31:0]     mem_q [DEPTH];

    logic            empty, full, push, pop, accept, addr_bad;

    assign empty      = (count_q == '0);
    assign full       = (count_q == DepthC);
    assign push_ready = !full;
    // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
    assign push       = push_valid && !full;
    assign fifo_count = count_q;

`ifdef IMEM_FIFO_ADDR_CHECK_EN
    logic [31:0] expected_q;
    logic [31:0] fetch_addr;
    logic        unused_inputs;

    // A fetch pipelined behind a completing read must target the word after the one in flight.
    assign fetch_addr    = pop ? expected_q + 32'd4 : expected_q;
    assign addr_bad      = (haddr != fetch_addr);
    assign unused_inputs = ^{hsize, hburst, hmastlock, hprot, hwdata, htrans[0]};

    // Expected fetch address advances only on a successful pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            expected_q <= START_ADDR;
        end else if (pop) begin
            expected_q <= expected_q + 32'd4;
        end
    end
`else
    logic unused_inputs;

    assign addr_bad      = 1'b0;
    assign unused_inputs = ^{hsize, hburst, hmastlock, hprot, hwdata, htrans[0], haddr,
                             START_ADDR};
`endif

    // Bus response for the current data phase and the next transfer state.
    always_comb begin
        state_d = state_q;
        hready  = 1'b1;
        hresp   = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: ;
            StRd: begin
                if (empty) begin
                    hready = 1'b0;
                end else begin
                    pop = 1'b1;
                end
            end
            StErr1: begin
                hready = 1'b0;
                hresp  = 1'b1;
            end
            StErr2: hresp = 1'b1;
            default: ;
        endcase

        // The address phase presented during the ERR2 cycle is deliberately dropped.
        accept = hready && htrans[1] && (state_q != StErr2);

        unique case (state_q)
            StErr1: state_d = StErr2;
            StErr2: state_d = StIdle;
            default: begin
                if (state_q == StRd && empty) begin
                    state_d = StRd;
                end else if (accept) begin
                    state_d = (hwrite || addr_bad) ? StErr1 : StRd;
                end else begin
                    state_d = StIdle;
                end
            end
        endcase
    end

    // Read data is driven only in the cycle a word actually leaves the FIFO.
    always_comb begin
        hrdata = '0;
        if (pop) begin
            hrdata = mem_q[rptr_q];
        end
    end

    // Transfer state, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (push) begin
                wptr_q <= wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

endmodule
